// File: rtl/video_timing_gen.sv
// Programmable video timing generator: pixel clock-enable, H/V counters, DE, syncs and
// character-cell counters, with double-buffered timing applied atomically at frame start.
module video_timing_gen #(
   parameter int unsigned HSZ      = 10,
   parameter int unsigned VSZ      = 10,
   parameter int unsigned PIX_DIV  = 4,
   parameter int unsigned CELL_W   = 8,
   parameter int unsigned CELL_H   = 8,
   parameter int unsigned H_ACT    = 640,
   parameter int unsigned H_FP     = 16,
   parameter int unsigned H_SYNC   = 96,
   parameter int unsigned H_BP     = 48,
   parameter int unsigned V_ACT    = 480,
   parameter int unsigned V_FP     = 10,
   parameter int unsigned V_SYNC   = 2,
   parameter int unsigned V_BP     = 33,
   parameter logic [2:0]  CTRL_RST = 3'b100
) (
   input  logic           clk_100mhz,
   input  logic           rstn_i,
   input  logic           cfg_we_i,
   input  logic [3:0]     cfg_addr_i,
   input  logic [15:0]    cfg_data_i,
   input  logic           cfg_commit_i,
   output logic           cfg_pending_o,
   output logic           pix_ce_o,
   output logic [HSZ-1:0] hcount_o,
   output logic [VSZ-1:0] vcount_o,
   output logic           de_o,
   output logic           hsync_o,
   output logic           vsync_o,
   output logic [3:0]     cell_col_o,
   output logic [3:0]     cell_row_o,
   output logic [HSZ-1:0] text_col_o,
   output logic [VSZ-1:0] text_row_o,
   output logic           line_start_o,
   output logic           frame_start_o
);

   localparam int unsigned TW    = ((HSZ > VSZ) ? HSZ : VSZ) + 2;
   localparam int unsigned DIV_W = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);
   localparam logic [3:0]       CW_LAST  = 4'(CELL_W - 1);
   localparam logic [3:0]       CH_LAST  = 4'(CELL_H - 1);
   // Timing register index: 0 act, 1 front porch, 2 sync, 3 back porch
   localparam logic [3:0][HSZ-1:0] H_RST = {HSZ'(H_BP), HSZ'(H_SYNC), HSZ'(H_FP), HSZ'(H_ACT)};
   localparam logic [3:0][VSZ-1:0] V_RST = {VSZ'(V_BP), VSZ'(V_SYNC), VSZ'(V_FP), VSZ'(V_ACT)};

   logic [3:0][HSZ-1:0] sh_h_q, sh_h_d, act_h_q, act_h_d;
   logic [3:0][VSZ-1:0] sh_v_q, sh_v_d, act_v_q, act_v_d;
   logic [2:0]          sh_ctrl_q, sh_ctrl_d, act_ctrl_q, act_ctrl_d;
   logic [DIV_W-1:0]    div_q, div_d;
   logic [HSZ-1:0]      h_q, h_d, tcol_q, tcol_d;
   logic [VSZ-1:0]      v_q, v_d, trow_q, trow_d;
   logic [3:0]          ccol_q, ccol_d, crow_q, crow_d;
   logic                pending_q, pending_d, restart_q, restart_d;
   logic                de_q, de_d, hsync_q, hsync_d, vsync_q, vsync_d;
   logic                pix_ce_q, pix_ce_d, line_start_q, line_start_d, frame_start_q, frame_start_d;

   logic          ce_c, hwrap_c, vwrap_c, apply_c, en_c, hs_on_c, vs_on_c;
   logic [TW-1:0] htot_c, vtot_c, hs_start_c, vs_start_c;
   logic          unused_data_c;

   assign unused_data_c = ^cfg_data_i;

   // Shadow/active registers, counters and registered outputs
   always_comb begin
      sh_h_d        = sh_h_q;
      sh_v_d        = sh_v_q;
      sh_ctrl_d     = sh_ctrl_q;
      act_h_d       = act_h_q;
      act_v_d       = act_v_q;
      act_ctrl_d    = act_ctrl_q;
      div_d         = div_q;
      h_d           = h_q;
      v_d           = v_q;
      ccol_d        = ccol_q;
      crow_d        = crow_q;
      tcol_d        = tcol_q;
      trow_d        = trow_q;
      restart_d     = restart_q;

      if (cfg_we_i) begin
         if (!cfg_addr_i[3]) begin
            if (!cfg_addr_i[2]) sh_h_d[cfg_addr_i[1:0]] = cfg_data_i[HSZ-1:0];
            else                sh_v_d[cfg_addr_i[1:0]] = cfg_data_i[VSZ-1:0];
         end else if (cfg_addr_i[2:0] == 3'd0) begin
            sh_ctrl_d = cfg_data_i[2:0];
         end
      end

      ce_c    = act_ctrl_q[2] && (div_q == DIV_LAST);
      htot_c  = TW'(act_h_q[0]) + TW'(act_h_q[1]) + TW'(act_h_q[2]) + TW'(act_h_q[3]);
      vtot_c  = TW'(act_v_q[0]) + TW'(act_v_q[1]) + TW'(act_v_q[2]) + TW'(act_v_q[3]);
      // A restart after re-enable behaves like a wrap so the first pixel is (0,0)
      hwrap_c = restart_q || (TW'(h_q) >= htot_c - TW'(1));
      vwrap_c = restart_q || (TW'(v_q) >= vtot_c - TW'(1));

      apply_c   = (pending_q || cfg_commit_i) &&
                  (!act_ctrl_q[2] || (ce_c && hwrap_c && vwrap_c));
      pending_d = (pending_q || cfg_commit_i) && !apply_c;
      if (apply_c) begin
         act_h_d    = sh_h_d;
         act_v_d    = sh_v_d;
         act_ctrl_d = sh_ctrl_d;
      end
      en_c = act_ctrl_d[2];

      if (!en_c) begin
         div_d     = '0;
         h_d       = '0;
         v_d       = '0;
         ccol_d    = '0;
         crow_d    = '0;
         tcol_d    = '0;
         trow_d    = '0;
         restart_d = 1'b1;
      end else begin
         div_d = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
         if (ce_c) begin
            restart_d = 1'b0;
            if (hwrap_c) begin
               h_d    = '0;
               ccol_d = '0;
               tcol_d = '0;
               if (vwrap_c) begin
                  v_d    = '0;
                  crow_d = '0;
                  trow_d = '0;
               end else begin
                  v_d = v_q + VSZ'(1);
                  if (crow_q == CH_LAST) begin
                     crow_d = '0;
                     trow_d = trow_q + VSZ'(1);
                  end else begin
                     crow_d = crow_q + 4'd1;
                  end
               end
            end else begin
               h_d = h_q + HSZ'(1);
               if (ccol_q == CW_LAST) begin
                  ccol_d = '0;
                  tcol_d = tcol_q + HSZ'(1);
               end else begin
                  ccol_d = ccol_q + 4'd1;
               end
            end
         end
      end

      // Outputs derive from next-state counters and timing so they align with hcount/vcount
      hs_start_c    = TW'(act_h_d[0]) + TW'(act_h_d[1]);
      vs_start_c    = TW'(act_v_d[0]) + TW'(act_v_d[1]);
      hs_on_c       = en_c && (TW'(h_d) >= hs_start_c) && (TW'(h_d) < hs_start_c + TW'(act_h_d[2]));
      vs_on_c       = en_c && (TW'(v_d) >= vs_start_c) && (TW'(v_d) < vs_start_c + TW'(act_v_d[2]));
      de_d          = en_c && (TW'(h_d) < TW'(act_h_d[0])) && (TW'(v_d) < TW'(act_v_d[0]));
      hsync_d       = hs_on_c ^ ~act_ctrl_d[0];
      vsync_d       = vs_on_c ^ ~act_ctrl_d[1];
      pix_ce_d      = en_c && (div_d == DIV_LAST);
      line_start_d  = en_c && ce_c && hwrap_c;
      frame_start_d = en_c && ce_c && hwrap_c && vwrap_c;
   end

   always_ff @(posedge clk_100mhz or negedge rstn_i) begin
      if (!rstn_i) begin
         sh_h_q        <= H_RST;
         sh_v_q        <= V_RST;
         sh_ctrl_q     <= CTRL_RST;
         act_h_q       <= H_RST;
         act_v_q       <= V_RST;
         act_ctrl_q    <= CTRL_RST;
         div_q         <= '0;
         h_q           <= '0;
         v_q           <= '0;
         ccol_q        <= '0;
         crow_q        <= '0;
         tcol_q        <= '0;
         trow_q        <= '0;
         pending_q     <= 1'b0;
         restart_q     <= ~CTRL_RST[2];
         de_q          <= 1'b0;
         hsync_q       <= ~CTRL_RST[0];
         vsync_q       <= ~CTRL_RST[1];
         pix_ce_q      <= 1'b0;
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         sh_h_q        <= sh_h_d;
         sh_v_q        <= sh_v_d;
         sh_ctrl_q     <= sh_ctrl_d;
         act_h_q       <= act_h_d;
         act_v_q       <= act_v_d;
         act_ctrl_q    <= act_ctrl_d;
         div_q         <= div_d;
         h_q           <= h_d;
         v_q           <= v_d;
         ccol_q        <= ccol_d;
         crow_q        <= crow_d;
         tcol_q        <= tcol_d;
         trow_q        <= trow_d;
         pending_q     <= pending_d;
         restart_q     <= restart_d;
         de_q          <= de_d;
         hsync_q       <= hsync_d;
         vsync_q       <= vsync_d;
         pix_ce_q      <= pix_ce_d;
         line_start_q  <= line_start_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign cfg_pending_o = pending_q;
   assign pix_ce_o      = pix_ce_q;
   assign hcount_o      = h_q;
   assign vcount_o      = v_q;
   assign de_o          = de_q;
   assign hsync_o       = hsync_q;
   assign vsync_o       = vsync_q;
   assign cell_col_o    = ccol_q;
   assign cell_row_o    = crow_q;
   assign text_col_o    = tcol_q;
   assign text_row_o    = trow_q;
   assign line_start_o  = line_start_q;
   assign frame_start_o = frame_start_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen using a small timing (24x15 total, 4x3 cells, PIX_DIV 4):
// expected pixel states are queued by the stimulus and checked by a monitor at each coordinate.
module tb_video_timing_gen;

   localparam int unsigned HSZ = 10;
   localparam int unsigned VSZ = 10;

   logic           clk_100mhz = 1'b0;
   logic           rstn_i     = 1'b0;
   logic           cfg_we_i   = 1'b0;
   logic [3:0]     cfg_addr_i = '0;
   logic [15:0]    cfg_data_i = '0;
   logic           cfg_commit_i = 1'b0;
   logic           cfg_pending_o, pix_ce_o, de_o, hsync_o, vsync_o, line_start_o, frame_start_o;
   logic [HSZ-1:0] hcount_o, text_col_o;
   logic [VSZ-1:0] vcount_o, text_row_o;
   logic [3:0]     cell_col_o, cell_row_o;

   always #5 clk_100mhz = ~clk_100mhz;

   video_timing_gen #(
      .HSZ(HSZ), .VSZ(VSZ), .PIX_DIV(4), .CELL_W(4), .CELL_H(3),
      .H_ACT(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
      .V_ACT(10), .V_FP(1), .V_SYNC(2), .V_BP(2), .CTRL_RST(3'b100)
   ) dut (
      .clk_100mhz(clk_100mhz), .rstn_i(rstn_i),
      .cfg_we_i(cfg_we_i), .cfg_addr_i(cfg_addr_i), .cfg_data_i(cfg_data_i),
      .cfg_commit_i(cfg_commit_i), .cfg_pending_o(cfg_pending_o),
      .pix_ce_o(pix_ce_o), .hcount_o(hcount_o), .vcount_o(vcount_o),
      .de_o(de_o), .hsync_o(hsync_o), .vsync_o(vsync_o),
      .cell_col_o(cell_col_o), .cell_row_o(cell_row_o),
      .text_col_o(text_col_o), .text_row_o(text_row_o),
      .line_start_o(line_start_o), .frame_start_o(frame_start_o)
   );

   typedef struct {
      int h; int v;
      bit de; bit hs; bit vs; bit pend;
      int ccol; int crow; int tcol; int trow;
   } rec_t;

   rec_t sbq[$];
   int   checks = 0;
   int   errors = 0;
   int   line_cnt = 0, frame_cnt = 0, de_cnt = 0, hs_cnt = 0;
   int   last_line = 0, last_frame = 0, last_de = 0, last_hs = 0, n_fs = 0;

   function automatic rec_t mk(input int h, input int v, input bit de, input bit hs, input bit vs,
                               input int cc, input int cr, input int tc, input int tr, input bit pend);
      rec_t r;
      r.h = h; r.v = v; r.de = de; r.hs = hs; r.vs = vs;
      r.ccol = cc; r.crow = cr; r.tcol = tc; r.trow = tr; r.pend = pend;
      return r;
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // Monitor: frame statistics plus scoreboard compare when the expected coordinate appears
   initial begin
      rec_t  r;
      string p;
      forever begin
         @(negedge clk_100mhz);
         if (rstn_i) begin
            if (line_start_o) begin
               last_line = line_cnt; last_hs = hs_cnt; line_cnt = 0; hs_cnt = 0;
            end
            if (frame_start_o) begin
               last_frame = frame_cnt; last_de = de_cnt; frame_cnt = 0; de_cnt = 0; n_fs++;
            end
            line_cnt  += int'(pix_ce_o);
            frame_cnt += int'(pix_ce_o);
            de_cnt    += int'(pix_ce_o && de_o);
            hs_cnt    += int'(pix_ce_o && !hsync_o);
            if (sbq.size() > 0 && int'(hcount_o) == sbq[0].h && int'(vcount_o) == sbq[0].v) begin
               r = sbq.pop_front();
               p = $sformatf("(%0d,%0d)", r.h, r.v);
               chk({p, " de"},       int'(de_o),          int'(r.de));
               chk({p, " hsync"},    int'(hsync_o),       int'(r.hs));
               chk({p, " vsync"},    int'(vsync_o),       int'(r.vs));
               chk({p, " cell_col"}, int'(cell_col_o),    r.ccol);
               chk({p, " cell_row"}, int'(cell_row_o),    r.crow);
               chk({p, " text_col"}, int'(text_col_o),    r.tcol);
               chk({p, " text_row"}, int'(text_row_o),    r.trow);
               chk({p, " pending"},  int'(cfg_pending_o), int'(r.pend));
            end
         end
      end
   end

   task automatic wait_sb(input int budget);
      for (int i = 0; i < budget && sbq.size() > 0; i++) @(negedge clk_100mhz);
      #1;
      if (sbq.size() > 0) begin
         chk($sformatf("scoreboard timeout at (%0d,%0d) left", sbq[0].h, sbq[0].v), sbq.size(), 0);
         sbq.delete();
      end
   endtask

   task automatic wait_hv(input int h, input int v, input int budget);
      int i;
      for (i = 0; i < budget; i++) begin
         @(negedge clk_100mhz);
         if (int'(hcount_o) == h && int'(vcount_o) == v) break;
      end
      #1;
      if (i == budget) chk($sformatf("wait for (%0d,%0d) timeout", h, v), 1, 0);
   endtask

   task automatic wait_fs(input int budget);
      int start = n_fs;
      int i;
      for (i = 0; i < budget && n_fs == start; i++) @(negedge clk_100mhz);
      #1;
      if (n_fs == start) chk("frame_start timeout", 1, 0);
   endtask

   task automatic cfg_write(input logic [3:0] a, input logic [15:0] d);
      @(negedge clk_100mhz);
      cfg_we_i = 1'b1; cfg_addr_i = a; cfg_data_i = d;
      @(negedge clk_100mhz);
      cfg_we_i = 1'b0;
   endtask

   task automatic commit();
      @(negedge clk_100mhz);
      cfg_commit_i = 1'b1;
      @(negedge clk_100mhz);
      cfg_commit_i = 1'b0;
      #1;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, " de"},          int'(de_o),          0);
      chk({tag, " hsync"},       int'(hsync_o),       1);
      chk({tag, " vsync"},       int'(vsync_o),       1);
      chk({tag, " hcount"},      int'(hcount_o),      0);
      chk({tag, " vcount"},      int'(vcount_o),      0);
      chk({tag, " pending"},     int'(cfg_pending_o), 0);
      chk({tag, " pix_ce"},      int'(pix_ce_o),      0);
      chk({tag, " text_col"},    int'(text_col_o),    0);
      chk({tag, " frame_start"}, int'(frame_start_o), 0);
   endtask

   initial begin
      int pce, fs;
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int pce, fs;
      #23;
      chk_reset_outputs("reset");
      @(negedge clk_100mhz);
      rstn_i = 1'b1;

      // Default timing: one full frame of hand-computed points, ending at the next (0,0)
      sbq.push_back(mk( 3, 0, 1,1,1, 3,0,0,0, 0));
      sbq.push_back(mk( 4, 0, 1,1,1, 0,0,1,0, 0));
      sbq.push_back(mk(15, 2, 1,1,1, 3,2,3,0, 0));
      sbq.push_back(mk(16, 2, 0,1,1, 0,2,4,0, 0));
      sbq.push_back(mk(18, 3, 0,0,1, 2,0,4,1, 0));
      sbq.push_back(mk(20, 3, 0,0,1, 0,0,5,1, 0));
      sbq.push_back(mk(21, 3, 0,1,1, 1,0,5,1, 0));
      sbq.push_back(mk(23, 9, 0,1,1, 3,0,5,3, 0));
      sbq.push_back(mk( 0,10, 0,1,1, 0,1,0,3, 0));
      sbq.push_back(mk( 5,11, 0,1,0, 1,2,1,3, 0));
      sbq.push_back(mk( 0,12, 0,1,0, 0,0,0,4, 0));
      sbq.push_back(mk( 0,13, 0,1,1, 0,1,0,4, 0));
      sbq.push_back(mk(23,14, 0,1,1, 3,2,5,4, 0));
      sbq.push_back(mk( 0, 0, 1,1,1, 0,0,0,0, 0));
      wait_sb(3000);
      wait_fs(2000);
      chk("frame length pix_ce", last_frame, 360);
      chk("frame de pixels",     last_de,    160);
      chk("line length pix_ce",  last_line,  24);
      chk("hsync low pixels",    last_hs,    3);

      // Mid-frame H_ACT=8: timing holds until the frame boundary, then htotal=16
      wait_hv(0, 5, 2000);
      cfg_write(4'd0, 16'd8);
      commit();
      chk("pending after commit", int'(cfg_pending_o), 1);
      sbq.push_back(mk(10, 6, 1,1,1, 2,0,2,2, 1));
      sbq.push_back(mk(23,14, 0,1,1, 3,2,5,4, 1));
      sbq.push_back(mk( 0, 0, 1,1,1, 0,0,0,0, 0));
      sbq.push_back(mk( 8, 0, 0,1,1, 0,0,2,0, 0));
      sbq.push_back(mk(10, 0, 0,0,1, 2,0,2,0, 0));
      sbq.push_back(mk(13, 0, 0,1,1, 1,0,3,0, 0));
      sbq.push_back(mk(15, 0, 0,1,1, 3,0,3,0, 0));
      sbq.push_back(mk( 0, 1, 1,1,1, 0,1,0,0, 0));
      wait_sb(3000);
      chk("new line length pix_ce", last_line, 16);
      chk("new hsync low pixels",   last_hs,   3);

      // Active-high syncs after the next boundary
      cfg_write(4'd8, 16'h0007);
      commit();
      sbq.push_back(mk( 5, 3, 1,1,1, 1,0,1,1, 1));
      sbq.push_back(mk( 0, 0, 1,0,0, 0,0,0,0, 0));
      sbq.push_back(mk(10, 0, 0,1,0, 2,0,2,0, 0));
      sbq.push_back(mk(13, 0, 0,0,0, 1,0,3,0, 0));
      sbq.push_back(mk( 0,11, 0,0,1, 0,2,0,3, 0));
      sbq.push_back(mk( 0,13, 0,0,0, 0,1,0,4, 0));
      wait_sb(3000);

      // Reset mid-frame with a commit pending: defaults return, commit discarded
      wait_hv(10, 7, 2000);
      cfg_write(4'd0, 16'd4);
      commit();
      chk("pending before reset", int'(cfg_pending_o), 1);
      #2;
      rstn_i = 1'b0;
      #1;
      chk_reset_outputs("async reset");
      repeat (3) @(negedge clk_100mhz);
      rstn_i = 1'b1;
      sbq.push_back(mk(12, 0, 1,1,1, 0,0,3,0, 0));
      sbq.push_back(mk(16, 0, 0,1,1, 0,0,4,0, 0));
      sbq.push_back(mk(18, 0, 0,0,1, 2,0,4,0, 0));
      sbq.push_back(mk( 0, 1, 1,1,1, 0,1,0,0, 0));
      wait_sb(3000);

      // Disable at the frame boundary, then re-enable immediately from (0,0)
      cfg_write(4'd8, 16'h0000);
      commit();
      for (int i = 0; i < 2000 && cfg_pending_o; i++) @(negedge clk_100mhz);
      #1;
      chk("disable pending cleared", int'(cfg_pending_o), 0);
      pce = 0; fs = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk_100mhz);
         pce += int'(pix_ce_o);
         fs  += int'(frame_start_o || line_start_o || de_o);
      end
      #1;
      chk("disabled pix_ce count", pce, 0);
      chk("disabled pulses/de",    fs,  0);
      chk("disabled hcount", int'(hcount_o), 0);
      chk("disabled vcount", int'(vcount_o), 0);
      chk("disabled hsync",  int'(hsync_o),  1);
      chk("disabled vsync",  int'(vsync_o),  1);
      cfg_write(4'd8, 16'h0004);
      commit();
      chk("enable pending cleared", int'(cfg_pending_o), 0);
      wait_fs(20);
      chk("restart hcount", int'(hcount_o), 0);
      chk("restart vcount", int'(vcount_o), 0);
      sbq.push_back(mk( 5, 0, 1,1,1, 1,0,1,0, 0));
      wait_sb(200);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
Parametrised successor to the fixed 640x480 timing/cell-counter logic in the graphics generator top level. It derives a pixel clock-enable from clk_100mhz and generates programmable H/V timing, DE, polarity-configurable syncs, and character-cell column/row counters for any cell size. Timing registers are double-buffered and applied atomically at a frame boundary, so software can re-mode the display without tearing. It feeds text/bitmap peripherals and the RGB output mux.

Parameters:
HSZ, 10, horizontal counter width
VSZ, 10, vertical counter width
PIX_DIV, 4, clk_100mhz cycles per pixel (>=1)
CELL_W, 8, cell width in pixels (1..16)
CELL_H, 8, cell height in lines (1..16)
H_ACT/H_FP/H_SYNC/H_BP, 640/16/96/48, reset horizontal timing
V_ACT/V_FP/V_SYNC/V_BP, 480/10/2/33, reset vertical timing
CTRL_RST, 3'b100, reset ctrl {en, vpol, hpol}; pol 0 = active-low

Ports:
clk_100mhz  in  1  system clock
rstn_i  in  1  reset; asynchronous, active-low
cfg_we_i  in  1  shadow register write strobe
cfg_addr_i  in  4  0..3 H_ACT,H_FP,H_SYNC,H_BP; 4..7 V_*; 8 ctrl; others ignored
cfg_data_i  in  16  write data, LSBs used (HSZ/VSZ/3 bits)
cfg_commit_i  in  1  request shadow->active transfer
cfg_pending_o  out  1  commit requested, not yet applied
pix_ce_o  out  1  pixel clock-enable pulse
hcount_o  out  HSZ  current pixel column
vcount_o  out  VSZ  current line
de_o  out  1  active video
hsync_o  out  1  horizontal sync (polarity per ctrl.hpol)
vsync_o  out  1  vertical sync (polarity per ctrl.vpol)
cell_col_o  out  4  pixel within cell
cell_row_o  out  4  line within cell
text_col_o  out  HSZ  cell column index
text_row_o  out  VSZ  cell row index
line_start_o  out  1  1-clk pulse when hcount moves to 0
frame_start_o  out  1  1-clk pulse when (h,v) moves to (0,0)

Behaviour:
- Reset (async assert, sync release on clk_100mhz): divider, all counters 0; de_o 0; syncs at inactive level per CTRL_RST; pulses 0; shadow and active regs = parameter defaults; pending 0.
- Divider counts 0..PIX_DIV-1; pix_ce_o high for the one clk where div==PIX_DIV-1. PIX_DIV=1 gives pix_ce_o constantly high.
- htotal = act+fp+sync+bp, computed at HSZ+2 bits; vtotal likewise.
- On pix_ce: h <= (h >= htotal-1) ? 0 : h+1. On h wrap, v <= (v >= vtotal-1) ? 0 : v+1. The >= compare guarantees recovery if totals shrink.
- All outputs are registered and coherent with hcount_o/vcount_o in the same cycle:
  - de_o = h<act_h && v<act_v.
  - hsync asserted for h in [act+fp, act+fp+sync); sync width 0 means never asserted. Vsync is the same on v.
  - Output level = asserted XOR ~pol.
- line_start_o and frame_start_o assert on the clk where the counters take the new (0) value.
- Cell counters update on pix_ce:
  - h wrap: cell_col 0, text_col 0.
  - Otherwise cell_col==CELL_W-1 gives cell_col 0 and text_col+1; else cell_col+1.
  - On h wrap: at v frame wrap, cell_row 0 and text_row 0. Else cell_row==CELL_H-1 gives cell_row 0 and text_row+1; else cell_row+1.
  - Counters run through blanking; consumers gate with de_o.
- Config:
  - cfg_we_i writes the shadow register at cfg_addr_i.
  - cfg_commit_i sets pending. Pending applies shadow->active on the pix_ce that wraps to (0,0), then clears.
  - A commit coincident with that boundary applies at that boundary.
  - Writes while pending modify the shadow and are included in the transfer.
  - If active ctrl.en=0, a pending commit applies on the next clk.
- ctrl.en=0: divider and counters held at 0, pix_ce_o 0, de_o 0, syncs inactive, pulses 0. Re-enable starts at (0,0), with frame_start_o on the first pix_ce.
- Reset mid-frame: outputs go to reset values immediately. A pending commit is discarded.

Test Plan:
- Defaults, PIX_DIV=4: pix_ce_o every 4th clk. frame_start_o every 800*525=420000 pix_ce. hsync_o low for exactly 96 pixels starting hcount 656. vsync_o low on lines 490..491.
- de_o count over one frame = 307200. First de at (0,0), last at (639,479). de_o 0 at h=640.
- Cell counters at defaults: h=7 gives cell_col 7/text_col 0; h=8 gives cell_col 0/text_col 1; v=8 gives text_row 1. At frame wrap all are 0.
- Mid-frame writes H_ACT=320 then commit at v=100: cfg_pending_o=1 and timing unchanged until frame end. Next frame htotal=480 and de_o high for h<320; pending drops at the wrap.
- Write ctrl=3'b111 and commit: after the boundary hsync_o/vsync_o are active-high (e.g. hsync_o=1 at h=656).
- Assert rstn_i low mid-frame (h=300, v=200) with commit pending: all outputs return to reset values asynchronously. After release counting restarts from 0 with default timing and pending 0.
